// File: rtl/join3_pkg.sv
// Shared types and helpers for the three-lane join/majority voter.
// maj3 is written at the widest supported lane width; callers size-cast in and out.
package join3_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    localparam int MAJ_MAX_W = 64;

    function automatic logic [MAJ_MAX_W-1:0] maj3(
        input logic [MAJ_MAX_W-1:0] a,
        input logic [MAJ_MAX_W-1:0] b,
        input logic [MAJ_MAX_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/join3_hold.sv
// One-entry valid/ready hold register for a single voter lane.
// Ready is low while full, so a token is never accepted on the edge that clears it.
module join3_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_take;

    assign o_ready = !r_full && !reset;
    assign w_take  = i_valid && o_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (w_take) begin
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/join3_voter.sv
// Joins three forked copies of a token and emits their bitwise majority,
// flagging and counting (saturating) any disagreement between the copies.
module join3_voter
    import join3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic             in1_valid,
    input  logic             in2_valid,
    output logic             in0_ready,
    output logic             in1_ready,
    output logic             in2_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic [WIDTH-1:0] in1_data,
    input  logic [WIDTH-1:0] in2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mismatch,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_h0, w_h1, w_h2;
    logic             w_full0, w_full1, w_full2;
    logic             w_all_full;
    logic             w_load;
    logic [WIDTH-1:0] w_maj;
    logic             w_mismatch;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_mismatch;
    logic [CNT_W-1:0] r_err_count;

    join3_hold #(.WIDTH(WIDTH)) u_hold0 (
        .clk(clk), .reset(reset), .i_valid(in0_valid), .o_ready(in0_ready),
        .i_data(in0_data), .i_clear(w_load), .o_data(w_h0), .o_full(w_full0)
    );

    join3_hold #(.WIDTH(WIDTH)) u_hold1 (
        .clk(clk), .reset(reset), .i_valid(in1_valid), .o_ready(in1_ready),
        .i_data(in1_data), .i_clear(w_load), .o_data(w_h1), .o_full(w_full1)
    );

    join3_hold #(.WIDTH(WIDTH)) u_hold2 (
        .clk(clk), .reset(reset), .i_valid(in2_valid), .o_ready(in2_ready),
        .i_data(in2_data), .i_clear(w_load), .o_data(w_h2), .o_full(w_full2)
    );

    assign w_all_full = w_full0 && w_full1 && w_full2;
    // A new triple may enter the output slot when it is empty or draining this edge.
    assign w_load     = w_all_full && ((r_state == COLLECT) || out_ready);
    assign w_maj      = WIDTH'(maj3(MAJ_MAX_W'(w_h0), MAJ_MAX_W'(w_h1), MAJ_MAX_W'(w_h2)));
    assign w_mismatch = !((w_h0 == w_h1) && (w_h1 == w_h2));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= COLLECT;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_mismatch <= 1'b0;
            r_err_count    <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_load) begin
                        r_out_valid    <= 1'b1;
                        r_out_data     <= w_maj;
                        r_out_mismatch <= w_mismatch;
                        r_state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_load) begin
                        r_out_data     <= w_maj;
                        r_out_mismatch <= w_mismatch;
                    end else if (out_ready) begin
                        r_out_valid    <= 1'b0;
                        r_state        <= COLLECT;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= COLLECT;
                end
            endcase
            if (w_load && w_mismatch && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_mismatch = r_out_mismatch;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_join3_voter.sv
// Bench for join3_voter: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against a queue-based transaction model.
module tb_join3_voter;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [2:0]   vld;
    logic [2:0]   rdy;
    logic [W-1:0] dat [3];
    logic         out_valid, out_ready, out_mismatch;
    logic [W-1:0] out_data;
    logic [15:0]  err_count;

    logic [2:0]   vld2;
    logic [2:0]   rdy2;
    logic [W-1:0] dat2 [3];
    logic         out_valid2, out_ready2, out_mismatch2;
    logic [W-1:0] out_data2;
    logic [1:0]   err_count2;

    join3_voter #(.WIDTH(W), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .in0_valid(vld[0]), .in1_valid(vld[1]), .in2_valid(vld[2]),
        .in0_ready(rdy[0]), .in1_ready(rdy[1]), .in2_ready(rdy[2]),
        .in0_data(dat[0]), .in1_data(dat[1]), .in2_data(dat[2]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mismatch(out_mismatch), .err_count(err_count)
    );

    join3_voter #(.WIDTH(W), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .in0_valid(vld2[0]), .in1_valid(vld2[1]), .in2_valid(vld2[2]),
        .in0_ready(rdy2[0]), .in1_ready(rdy2[1]), .in2_ready(rdy2[2]),
        .in0_data(dat2[0]), .in1_data(dat2[1]), .in2_data(dat2[2]),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_mismatch(out_mismatch2), .err_count(err_count2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference helpers written from the voting rules, bit by bit.
    function automatic logic [W-1:0] ref_maj(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) begin
            int ones;
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (ones >= 2);
        end
        return r;
    endfunction

    typedef struct {
        logic [W-1:0] d0, d1, d2;
        logic [W-1:0] exp_data;
        logic         exp_mm;
        logic [15:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         mm;
    } res_t;

    vec_t vecs [5];

    logic [W-1:0] lq [3][$];
    res_t         oq [$];
    int           merr;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 16'd0};
        vecs[1] = '{8'hF0, 8'hF0, 8'h0F, 8'hF0, 1'b1, 16'd1};
        vecs[2] = '{8'hCC, 8'hAA, 8'hF0, 8'hE8, 1'b1, 16'd2};
        vecs[3] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 16'd2};
        vecs[4] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 16'd3};

        reset = 1'b1; vld = '0; out_ready = 1'b0;
        vld2 = '0; out_ready2 = 1'b1;
        for (int i = 0; i < 3; i++) begin dat[i] = '0; dat2[i] = '0; end
        tick(); tick();
        chk("reset_ready", {29'd0, rdy}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {24'd0, out_data}, 32'd0);
        chk("reset_mm", {31'd0, out_mismatch}, 32'd0);
        chk("reset_err", {16'd0, err_count}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", {29'd0, rdy}, 32'd7);

        // Table: all lanes together, one-cycle load latency, immediate drain.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat[0] = vecs[i].d0; dat[1] = vecs[i].d1; dat[2] = vecs[i].d2;
            vld = 3'b111;
            tick();
            vld = '0;
            chk("tbl_no_early_valid", {31'd0, out_valid}, 32'd0);
            chk("tbl_ready_low_held", {29'd0, rdy}, 32'd0);
            tick();
            chk("tbl_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl_data", {24'd0, out_data}, {24'd0, vecs[i].exp_data});
            chk("tbl_mm", {31'd0, out_mismatch}, {31'd0, vecs[i].exp_mm});
            chk("tbl_err", {16'd0, err_count}, {16'd0, vecs[i].exp_err});
            chk("tbl_ready_back", {29'd0, rdy}, 32'd7);
            tick();
            chk("tbl_drain", {31'd0, out_valid}, 32'd0);
        end

        // Skewed arrival: lane1 five cycles after lane0, lane2 after nine.
        for (int c = 0; c < 12; c++) begin
            dat[0] = 8'h81; dat[1] = 8'h81; dat[2] = 8'h80;
            vld = {c == 9, c == 5, c == 0};
            tick();
            vld = '0;
            chk("skew_valid", {31'd0, out_valid}, {31'd0, c == 10});
            chk("skew_rdy0", {31'd0, rdy[0]}, {31'd0, !(c <= 9)});
            chk("skew_rdy1", {31'd0, rdy[1]}, {31'd0, !(c >= 5 && c <= 9)});
            chk("skew_rdy2", {31'd0, rdy[2]}, {31'd0, c != 9});
            if (c == 10) begin
                chk("skew_data", {24'd0, out_data}, 32'h81);
                chk("skew_mm", {31'd0, out_mismatch}, 32'd1);
                chk("skew_err", {16'd0, err_count}, 32'd4);
            end
        end

        // Back-pressure with the next triple queued, then back-to-back load.
        out_ready = 1'b0;
        dat[0] = 8'h11; dat[1] = 8'h11; dat[2] = 8'h11; vld = 3'b111;
        tick(); vld = '0;
        tick();
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_first_data", {24'd0, out_data}, 32'h11);
        dat[0] = 8'h22; dat[1] = 8'h22; dat[2] = 8'h23; vld = 3'b111;
        tick(); vld = '0;
        for (int k = 0; k < 6; k++) begin
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, out_data}, 32'h11);
            chk("bp_hold_mm", {31'd0, out_mismatch}, 32'd0);
            chk("bp_hold_ready", {29'd0, rdy}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_b2b_data", {24'd0, out_data}, 32'h22);
        chk("bp_b2b_mm", {31'd0, out_mismatch}, 32'd1);
        chk("bp_b2b_err", {16'd0, err_count}, 32'd5);
        chk("bp_b2b_ready", {29'd0, rdy}, 32'd7);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two lanes full discards them.
        dat[0] = 8'hAA; dat[1] = 8'hAA; vld = 3'b011;
        tick(); vld = '0;
        chk("rst_partial_ready", {29'd0, rdy}, 32'd4);
        reset = 1'b1;
        #1;
        chk("rst_ready_low", {29'd0, rdy}, 32'd0);
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {16'd0, err_count}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_after_ready", {29'd0, rdy}, 32'd7);
        dat[2] = 8'h77; vld = 3'b100;
        tick(); vld = '0;
        tick(); tick();
        chk("rst_no_output", {31'd0, out_valid}, 32'd0);
        chk("rst_lane2_only", {29'd0, rdy}, 32'd3);
        dat[0] = 8'h3C; dat[1] = 8'h3C; vld = 3'b011;
        tick(); vld = '0;
        tick();
        chk("rst_vote_valid", {31'd0, out_valid}, 32'd1);
        chk("rst_vote_data", {24'd0, out_data}, 32'h3C);
        chk("rst_vote_mm", {31'd0, out_mismatch}, 32'd1);
        chk("rst_vote_err", {16'd0, err_count}, 32'd1);
        tick();

        // Narrow counter saturates at 3.
        for (int n = 0; n < 5; n++) begin
            dat2[0] = 8'h01; dat2[1] = 8'h01; dat2[2] = 8'h02; vld2 = 3'b111;
            tick(); vld2 = '0;
            tick();
            chk("sat_valid", {31'd0, out_valid2}, 32'd1);
            chk("sat_data", {24'd0, out_data2}, 32'h01);
            chk("sat_err", {30'd0, err_count2}, (n + 1 > 3) ? 32'd3 : 32'(n + 1));
            tick();
        end

        // Randomized run against the transaction model.
        reset = 1'b1; vld = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) lq[i].delete();
        oq.delete();
        merr = 0;
        #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [2:0] acc;
            logic       drain, load;
            for (int i = 0; i < 3; i++) begin
                vld[i] = ($urandom_range(0, 9) < 6);
                dat[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : 8'hC5 ^ W'(cyc & 3);
            end
            out_ready = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 3; i++)
                chk("rnd_ready", {31'd0, rdy[i]}, {31'd0, lq[i].size() == 0});
            chk("rnd_valid", {31'd0, out_valid}, {31'd0, oq.size() != 0});
            if (oq.size() != 0) begin
                chk("rnd_data", {24'd0, out_data}, {24'd0, oq[0].d});
                chk("rnd_mm", {31'd0, out_mismatch}, {31'd0, oq[0].mm});
            end
            chk("rnd_err", {16'd0, err_count}, 32'(merr));

            for (int i = 0; i < 3; i++) acc[i] = vld[i] && (lq[i].size() == 0);
            drain = (oq.size() != 0) && out_ready;
            load  = (lq[0].size() == 1) && (lq[1].size() == 1) && (lq[2].size() == 1)
                    && ((oq.size() == 0) || out_ready);
            if (drain) void'(oq.pop_front());
            if (load) begin
                res_t r;
                logic [W-1:0] a, b, c;
                a = lq[0].pop_front(); b = lq[1].pop_front(); c = lq[2].pop_front();
                r.d  = ref_maj(a, b, c);
                r.mm = !((a == b) && (b == c));
                oq.push_back(r);
                if (r.mm && merr < 65535) merr++;
            end
            for (int i = 0; i < 3; i++) if (acc[i]) lq[i].push_back(dat[i]);
            tick();
        end
        vld = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
